// File: rtl/reg_file.sv
// Integer register file (x0 hardwired to zero) with pending-write scoreboard,
// hazard-gated one-cycle operand read and write-to-read bypass.
module reg_file (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reg_w_enabled,
  input  logic [4:0]  reg_w_addr,
  input  logic [31:0] reg_w_data,
  input  logic        rd_en,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rd_ready,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        rd_valid,
  input  logic        busy_set,
  input  logic [4:0]  busy_addr,
  output logic [31:0] busy
);

  logic [31:0] r_regs [1:31];
  logic [31:0] r_busy;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic        r_valid;

  logic        w_wr;
  logic        w_haz1;
  logic        w_haz2;
  logic        w_accept;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_busy_nxt;

  // A pending register stops being a hazard in the cycle its write-back arrives.
  function automatic logic src_hazard(input logic [4:0]  a,
                                      input logic [31:0] sb,
                                      input logic        we,
                                      input logic [4:0]  wa);
    return (a != 5'd0) && sb[a] && !(we && (wa == a));
  endfunction

  assign w_wr     = reg_w_enabled && (reg_w_addr != 5'd0);
  assign w_haz1   = src_hazard(rs1_addr, r_busy, reg_w_enabled, reg_w_addr);
  assign w_haz2   = src_hazard(rs2_addr, r_busy, reg_w_enabled, reg_w_addr);
  assign rd_ready = !(rd_en && (w_haz1 || w_haz2));
  assign w_accept = rd_en && rd_ready;

  // Operand select: x0 is zero, a same-cycle write is bypassed, else storage.
  always_comb begin
    w_rs1_val = 32'd0;
    w_rs2_val = 32'd0;
    if (rs1_addr == 5'd0) begin
      w_rs1_val = 32'd0;
    end else if (w_wr && (reg_w_addr == rs1_addr)) begin
      w_rs1_val = reg_w_data;
    end else begin
      w_rs1_val = r_regs[rs1_addr];
    end
    if (rs2_addr == 5'd0) begin
      w_rs2_val = 32'd0;
    end else if (w_wr && (reg_w_addr == rs2_addr)) begin
      w_rs2_val = reg_w_data;
    end else begin
      w_rs2_val = r_regs[rs2_addr];
    end
  end

  // Scoreboard next state: clear on write-back, then set on issue so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) begin
      w_busy_nxt[reg_w_addr] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (busy_set && (busy_addr != 5'd0)) begin
      w_busy_nxt[busy_addr] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Storage, scoreboard and read-port registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
      r_busy  <= 32'd0;
      r_rs1   <= 32'd0;
      r_rs2   <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_regs[reg_w_addr] <= reg_w_data;
      end
      r_busy  <= w_busy_nxt;
      r_valid <= w_accept;
      if (w_accept) begin
        r_rs1 <= w_rs1_val;
        r_rs2 <= w_rs2_val;
      end
    end
  end

  assign busy     = r_busy;
  assign rs1_data = r_rs1;
  assign rs2_data = r_rs2;
  assign rd_valid = r_valid;

endmodule
